// File: rtl/framebuffer_prefetch_reader.sv
// Prefetches framebuffer lines from PSRAM into a ping-pong line buffer and
// streams them as RGB565 pixels in the video clock domain.
module framebuffer_prefetch_reader #(
  parameter int MAX_WIDTH = 2048,
  parameter int BURST     = 32,
  parameter int AW        = 21
) (
  input  logic          i_psram_clk,
  input  logic          i_psram_rst_n,
  input  logic          i_video_clk,
  input  logic          i_video_rst_n,
  input  logic [AW-1:0] i_reg_base_addr,
  input  logic [AW-1:0] i_reg_stride,
  input  logic [11:0]   i_reg_width,
  input  logic [11:0]   i_reg_start_line,
  input  logic [11:0]   i_reg_end_line,
  input  logic          i_reg_vscale2x,
  input  logic          i_underflow_clr,
  output logic          o_psram_req,
  input  logic          i_psram_gnt,
  output logic [AW-1:0] o_psram_addr,
  input  logic [63:0]   i_psram_data,
  input  logic          i_psram_data_valid,
  input  logic          i_video_hsync,
  input  logic          i_video_vsync,
  input  logic          i_video_active,
  output logic          o_video_hsync,
  output logic          o_video_vsync,
  output logic          o_video_active,
  output logic [15:0]   o_video_data,
  output logic          o_underflow
);
  localparam int WORDS = MAX_WIDTH / 4;
  localparam int WA    = $clog2(WORDS);
  localparam int BEATS = BURST / 4;
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [63:0] line_buf [0:2*WORDS-1];

  // ---------------- PSRAM domain ----------------
  logic [2:0]  hs_sync, vs_sync;
  logic        hs_rise, vs_fall, vs_high;
  logic [11:0] ps_line;

  always_ff @(posedge i_psram_clk or negedge i_psram_rst_n) begin
    if (!i_psram_rst_n) begin
      hs_sync <= '0;
      vs_sync <= '0;
      ps_line <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      hs_sync <= {hs_sync[1:0], i_video_hsync};
      vs_sync <= {vs_sync[1:0], i_video_vsync};
      if (vs_high)      ps_line <= '1;
      else if (hs_rise) ps_line <= ps_line + 12'd1;
    end
  end

  assign hs_rise = hs_sync[1] & ~hs_sync[2];
  assign vs_fall = ~vs_sync[1] & vs_sync[2];
  assign vs_high = vs_sync[1];

  // An hsync that moves the counter to n prefetches line n+1.
  logic        trig, trig_q, busy_trig;
  logic [11:0] target;
  assign trig   = vs_fall | (hs_rise & ~vs_high);
  assign target = vs_fall ? 12'd0 : ps_line + 12'd2;
  assign trig_q = trig && (target >= i_reg_start_line) && (target < i_reg_end_line)
                  && (i_reg_width != 12'd0);

  logic [1:0]    state;
  logic [11:0]   idx;
  logic [BW-1:0] beat;
  logic [WA-1:0] wr_word;
  logic          tgt_bank, pend, pend_bank, vs_pend, fetch_par;
  logic [AW-1:0] line_addr;

  logic [11:0]   n_bursts;
  logic          last_beat, last_burst, pend_now, restart_bank;
  logic [AW-1:0] next_line_addr, restart_addr;

  assign busy_trig    = trig_q && (state != ST_IDLE);
  assign n_bursts     = i_reg_width / 12'(BURST);
  assign last_beat    = i_psram_data_valid && (beat == BW'(BEATS - 1));
  assign last_burst   = (idx + 12'd1) >= n_bursts;
  assign pend_now     = pend | busy_trig;
  assign restart_bank = busy_trig ? target[0] : pend_bank;
  // With 2x vertical scaling the source line advances every second fetch.
  assign next_line_addr = (i_reg_vscale2x && !fetch_par) ? line_addr : line_addr + i_reg_stride;
  assign restart_addr   = vs_pend ? line_addr : next_line_addr;

  always_ff @(posedge i_psram_clk or negedge i_psram_rst_n) begin
    if (!i_psram_rst_n) begin
      state        <= ST_IDLE;
      o_psram_req  <= 1'b0;
      o_psram_addr <= '0;
      o_underflow  <= 1'b0;
      idx          <= '0;
      beat         <= '0;
      wr_word      <= '0;
      tgt_bank     <= 1'b0;
      pend         <= 1'b0;
      pend_bank    <= 1'b0;
      vs_pend      <= 1'b0;
      fetch_par    <= 1'b0;
      line_addr    <= '0;
    end else begin
      if (busy_trig)            o_underflow <= 1'b1;
      else if (i_underflow_clr) o_underflow <= 1'b0;

      if (busy_trig) begin
        pend      <= 1'b1;
        pend_bank <= target[0];
      end
      if (vs_high && state != ST_IDLE) vs_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (trig_q) begin
            state        <= ST_REQ;
            o_psram_req  <= 1'b1;
            o_psram_addr <= line_addr;
            idx          <= '0;
            tgt_bank     <= target[0];
          end
        end
        ST_REQ: begin
          if (i_psram_gnt) begin
            state       <= ST_DATA;
            o_psram_req <= 1'b0;
            beat        <= '0;
            wr_word     <= WA'(idx * 12'(BEATS));
          end
        end
        ST_DATA: begin
          if (i_psram_data_valid) begin
            beat    <= beat + BW'(1);
            wr_word <= wr_word + WA'(1);
          end
          if (last_beat) begin
            if (pend_now) begin
              // Overrun: abandon the rest of the old line, restart on the new target.
              state        <= ST_REQ;
              o_psram_req  <= 1'b1;
              o_psram_addr <= restart_addr;
              idx          <= '0;
              tgt_bank     <= restart_bank;
              pend         <= 1'b0;
              vs_pend      <= 1'b0;
              if (!vs_pend) begin
                line_addr <= next_line_addr;
                fetch_par <= ~fetch_par;
              end
            end else if (vs_pend || vs_high) begin
              state   <= ST_IDLE;
              vs_pend <= 1'b0;
            end else if (!last_burst) begin
              state        <= ST_REQ;
              o_psram_req  <= 1'b1;
              o_psram_addr <= line_addr + AW'(idx + 12'd1) * AW'(BURST);
              idx          <= idx + 12'd1;
            end else begin
              state     <= ST_IDLE;
              line_addr <= next_line_addr;
              fetch_par <= ~fetch_par;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (vs_high) begin
        line_addr <= i_reg_base_addr;
        fetch_par <= 1'b0;
        pend      <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer has no reset; it maps to RAM, and every word is
  // written before the video side can legally display it.
  always_ff @(posedge i_psram_clk) begin
    if (state == ST_DATA && i_psram_data_valid)
      line_buf[{tgt_bank, wr_word}] <= i_psram_data;
  end

  // ---------------- Video domain ----------------
  logic [11:0] v_line, pix_idx;
  logic        v_hs_d, show;
  logic [WA:0] rd_addr;
  logic [63:0] rd_word;
  logic [15:0] rd_pix;

  assign show    = (v_line >= i_reg_start_line) && (v_line < i_reg_end_line)
                   && (pix_idx < i_reg_width);
  assign rd_addr = {v_line[0], pix_idx[WA+1:2]};
  assign rd_word = line_buf[rd_addr];
  assign rd_pix  = rd_word[{pix_idx[1:0], 4'd0} +: 16];

  always_ff @(posedge i_video_clk or negedge i_video_rst_n) begin
    if (!i_video_rst_n) begin
      v_line         <= '1;
      pix_idx        <= '0;
      v_hs_d         <= 1'b0;
      o_video_hsync  <= 1'b0;
      o_video_vsync  <= 1'b0;
      o_video_active <= 1'b0;
      o_video_data   <= '0;
    end else begin
      v_hs_d <= i_video_hsync;
      if (i_video_vsync)                      v_line <= '1;
      else if (i_video_hsync && !v_hs_d)      v_line <= v_line + 12'd1;
      if (i_video_hsync)       pix_idx <= '0;
      else if (i_video_active) pix_idx <= pix_idx + 12'd1;
      o_video_hsync  <= i_video_hsync;
      o_video_vsync  <= i_video_vsync;
      o_video_active <= i_video_active;
      o_video_data   <= show ? rd_pix : 16'd0;
    end
  end

endmodule

// File: tb/tb_framebuffer_prefetch_reader.sv
// Directed bench: a small PSRAM responder serves bursts whose pixel values
// equal their pixel address, so video output can be predicted directly.
module tb_framebuffer_prefetch_reader;
  logic        pclk = 1'b0, vclk = 1'b0;
  logic        prst_n, vrst_n;
  logic [20:0] base, stride;
  logic [11:0] width, start_line, end_line;
  logic        vscale2x, uf_clr;
  logic        req, gnt;
  logic [20:0] addr;
  logic [63:0] pdata;
  logic        pvalid;
  logic        hsync, vsync, active;
  logic        o_hs, o_vs, o_act;
  logic [15:0] o_data;
  logic        uf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 pclk = ~pclk;
  always #8 vclk = ~vclk;

  framebuffer_prefetch_reader dut (
    .i_psram_clk(pclk), .i_psram_rst_n(prst_n),
    .i_video_clk(vclk), .i_video_rst_n(vrst_n),
    .i_reg_base_addr(base), .i_reg_stride(stride), .i_reg_width(width),
    .i_reg_start_line(start_line), .i_reg_end_line(end_line),
    .i_reg_vscale2x(vscale2x), .i_underflow_clr(uf_clr),
    .o_psram_req(req), .i_psram_gnt(gnt), .o_psram_addr(addr),
    .i_psram_data(pdata), .i_psram_data_valid(pvalid),
    .i_video_hsync(hsync), .i_video_vsync(vsync), .i_video_active(active),
    .o_video_hsync(o_hs), .o_video_vsync(o_vs), .o_video_active(o_act),
    .o_video_data(o_data), .o_underflow(uf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mk_word(input logic [20:0] a, input int b);
    logic [15:0] p;
    p = 16'(a) + 16'(4 * b);
    return {p + 16'd3, p + 16'd2, p + 16'd1, p};
  endfunction

  task automatic wait_req(input logic [20:0] exp_addr, input string tag);
    int n;
    n = 0;
    @(negedge pclk);
    while (!req && n < 300) begin
      @(negedge pclk);
      n++;
    end
    check({tag, "_req"}, 64'(req), 64'(1));
    check({tag, "_addr"}, 64'(addr), 64'(exp_addr));
  endtask

  task automatic grant_data(input logic [20:0] a, input int beats, input string tag);
    @(posedge pclk); #1 gnt = 1'b1;
    @(posedge pclk); #1 gnt = 1'b0;
    @(negedge pclk);
    check({tag, "_req_drop"}, 64'(req), 64'(0));
    for (int b = 0; b < beats; b++) begin
      pdata  = mk_word(a, b);
      pvalid = 1'b1;
      @(posedge pclk); #1;
    end
    pvalid = 1'b0;
  endtask

  task automatic serve(input logic [20:0] a, input string tag);
    wait_req(a, tag);
    grant_data(a, 8, tag);
  endtask

  task automatic no_req(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge pclk);
      seen = seen | req;
    end
    check(tag, 64'(seen), 64'(0));
  endtask

  task automatic hsync_pulse();
    @(posedge vclk); #1 hsync = 1'b1;
    repeat (4) @(posedge vclk);
    #1 hsync = 1'b0;
    repeat (2) @(posedge vclk);
  endtask

  task automatic vsync_pulse();
    @(posedge vclk); #1 vsync = 1'b1;
    @(posedge vclk);
    @(negedge vclk);
    check("vsync_delayed", 64'(o_vs), 64'(1));
    repeat (5) @(posedge vclk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge vclk);
  endtask

  // One displayed line of 65 active pixels; the last one lies past the width.
  task automatic video_line(input logic [20:0] line_base, input bit on, input string tag);
    logic [15:0] exp;
    hsync_pulse();
    #1 active = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      @(posedge vclk);
      @(negedge vclk);
      exp = (on && k < 64) ? 16'(line_base) + 16'(k) : 16'd0;
      check($sformatf("%s_px%0d", tag, k), 64'(o_data), 64'(exp));
      if (k == 0) check({tag, "_active_aligned"}, 64'(o_act), 64'(1));
    end
    active = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prst_n = 1'b0; vrst_n = 1'b0;
    base = 21'h100; stride = 21'd64; width = 12'd64;
    start_line = 12'd0; end_line = 12'd480; vscale2x = 1'b0; uf_clr = 1'b0;
    gnt = 1'b0; pdata = '0; pvalid = 1'b0;
    hsync = 1'b0; vsync = 1'b0; active = 1'b0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_req", 64'(req), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_underflow", 64'(uf), 64'(0));
    @(negedge vclk);
    check("rst_vdata", 64'(o_data), 64'(0));
    check("rst_vhsync", 64'(o_hs), 64'(0));
    check("rst_vactive", 64'(o_act), 64'(0));
    @(posedge pclk); #1 prst_n = 1'b1; vrst_n = 1'b1;

    // Line 0 prefetched on vsync fall into bank 0.
    vsync_pulse();
    serve(21'h100, "l0_b0");
    serve(21'h120, "l0_b1");
    no_req(30, "l0_idle");

    // Line 0 displayed from bank 0 while line 1 fetches into bank 1, then line 1.
    fork
      begin serve(21'h140, "l1_b0"); serve(21'h160, "l1_b1"); end
      video_line(21'h100, 1'b1, "vl0");
    join
    fork
      begin serve(21'h180, "l2_b0"); serve(21'h1A0, "l2_b1"); end
      video_line(21'h140, 1'b1, "vl1");
    join

    // Grant withheld across an hsync: overrun, old line dropped.
    hsync_pulse();
    wait_req(21'h1C0, "uf_b0");
    check("uf_before", 64'(uf), 64'(0));
    hsync_pulse();
    repeat (6) @(negedge pclk);
    check("uf_set", 64'(uf), 64'(1));
    check("uf_req_held", 64'(req), 64'(1));
    check("uf_addr_held", 64'(addr), 64'(21'h1C0));
    grant_data(21'h1C0, 8, "uf_b0");
    serve(21'h200, "uf_new_b0");
    serve(21'h220, "uf_new_b1");
    no_req(20, "uf_idle");
    check("uf_sticky", 64'(uf), 64'(1));
    @(posedge pclk); #1 uf_clr = 1'b1;
    @(posedge pclk); #1 uf_clr = 1'b0;
    @(negedge pclk);
    check("uf_cleared", 64'(uf), 64'(0));

    // Vertical 2x: each source line fetched for two target lines.
    vscale2x = 1'b1;
    vsync_pulse();
    serve(21'h100, "vs_t0_b0"); serve(21'h120, "vs_t0_b1");
    hsync_pulse();
    serve(21'h100, "vs_t1_b0"); serve(21'h120, "vs_t1_b1");
    hsync_pulse();
    serve(21'h140, "vs_t2_b0"); serve(21'h160, "vs_t2_b1");
    hsync_pulse();
    serve(21'h140, "vs_t3_b0"); serve(21'h160, "vs_t3_b1");
    no_req(20, "vs_idle");

    // Window 10..20: nothing fetched or shown for early lines.
    vscale2x = 1'b0; start_line = 12'd10; end_line = 12'd20;
    vsync_pulse();
    repeat (5) hsync_pulse();
    no_req(20, "win_pre");
    video_line(21'h0, 1'b0, "vl5");
    repeat (3) hsync_pulse();
    no_req(20, "win_pre9");
    hsync_pulse();
    wait_req(21'h100, "win_t10");

    // Reset in the middle of a burst.
    @(posedge pclk); #1 gnt = 1'b1;
    @(posedge pclk); #1 gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      pdata = mk_word(21'h100, b); pvalid = 1'b1;
      @(posedge pclk); #1;
    end
    pvalid = 1'b0;
    prst_n = 1'b0;
    @(negedge pclk);
    check("mid_rst_req", 64'(req), 64'(0));
    check("mid_rst_addr", 64'(addr), 64'(0));
    @(posedge pclk); #1 prst_n = 1'b1;
    start_line = 12'd0; end_line = 12'd480;
    no_req(20, "post_rst_idle");
    vsync_pulse();
    serve(21'h100, "post_rst_b0");
    serve(21'h120, "post_rst_b1");
    check("post_rst_uf", 64'(uf), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/framebuffer_prefetch_reader.md
FRAMEBUFFER_PREFETCH_READER -- requirements
Module: framebuffer_prefetch_reader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- MAX_WIDTH, 2048, max pixels per line.
- BURST, 32, pixels per PSRAM burst; multiple of 4.
- AW, 21, PSRAM address width in 16-bit pixel units.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- i_psram_clk, in, 1, PSRAM clock.
- i_psram_rst_n, in, 1, reset; asynchronous, active-low.
- i_video_clk, in, 1, video clock.
- i_video_rst_n, in, 1, video reset; async, active-low.
- i_reg_base_addr, in, AW, frame base address.
- i_reg_stride, in, AW, line pitch in pixels.
- i_reg_width, in, 12, active pixels per line; multiple of BURST.
- i_reg_start_line, in, 12, first displayed line of the window.
- i_reg_end_line, in, 12, window end line (exclusive).
- i_reg_vscale2x, in, 1, repeat each source line twice.
- i_underflow_clr, in, 1, clears o_underflow (PSRAM domain).
- o_psram_req, out, 1, burst request.
- i_psram_gnt, in, 1, 1-cycle grant.
- o_psram_addr, out, AW, burst start address.
- i_psram_data, in, 64, four pixels; pixel 0 in [15:0].
- i_psram_data_valid, in, 1, data word strobe.
- i_video_hsync, in, 1, video hsync.
- i_video_vsync, in, 1, video vsync.
- i_video_active, in, 1, video active.
- o_video_hsync, out, 1, delayed hsync.
- o_video_vsync, out, 1, delayed vsync.
- o_video_active, out, 1, delayed active.
- o_video_data, out, 16, RGB565 pixel.
- o_underflow, out, 1, sticky prefetch-overrun flag (PSRAM domain).

Function
REQ-003 hsync/vsync SHALL cross into the PSRAM domain via 3-FF synchronisers; rising-edge pulses come from stages [2:1]; a vsync-fall pulse is also derived.
REQ-004 Both domains SHALL keep a 12-bit line counter:
- Held at 12'hFFF while vsync is high.
- Incremented on each hsync rising edge, so the first line after vsync is 0.
REQ-005 Fetch trigger: the vsync-fall pulse targets line 0; an hsync pulse that sets the counter to n targets line n+1.
- A fetch is issued only if start_line <= target < end_line and width != 0.
REQ-006 Line data SHALL be written to bank target[0] of a 2-bank ping-pong line buffer.
- Buffer is 2 x MAX_WIDTH/4 words of 64 bits, read 16 bits wide.
- Video reads bank n[0] during line n.
REQ-007 Line address:
- Set to i_reg_base_addr on vsync.
- After each completed line fetch, it advances by i_reg_stride; with vscale2x=1, after every second fetch.
- Arithmetic is modulo 2^AW.
REQ-008 FSM states SHALL be IDLE, REQ, DATA.
- IDLE->REQ on a qualified trigger; burst index = 0.
- REQ: o_psram_req=1, o_psram_addr = line_addr + idx*BURST; on i_psram_gnt go to DATA and drop req the next cycle.
- DATA: count BURST/4 data_valid words into consecutive buffer words, then REQ if idx+1 < width/BURST, else IDLE.
REQ-009 A trigger arriving outside IDLE SHALL set o_underflow.
- The current burst finishes DATA; the FSM then restarts for the new target, and the rest of the old line is dropped.
REQ-010 vsync rising mid-fetch: the current burst completes, then the FSM returns to IDLE and no further bursts are issued.
REQ-011 o_underflow SHALL stay set until i_underflow_clr. Set and clear in the same cycle: set wins.
REQ-012 Video pixel index:
- Cleared while i_video_hsync is high; incremented when i_video_active is high.
- Read address = {n[0], index}.
REQ-013 o_video_data SHALL be 0 when line n is outside the window or index >= width. Data and sync outputs have 1 i_video_clk latency and are aligned.

Reset
REQ-014 i_psram_rst_n low SHALL force:
- FSM=IDLE, o_psram_req=0, o_psram_addr=0, o_underflow=0, PSRAM line counter=12'hFFF.
- Any in-flight burst is abandoned.
REQ-015 i_video_rst_n low SHALL force the video line counter=12'hFFF, pixel index=0, and o_video_* = 0.

Verification
REQ-016 Width=64, BURST=32, base=0x100, stride=64, window 0..480, vsync fall -> two bursts at addr 0x100, 0x120; 16 words into bank 0.
REQ-017 Same setup, hsync making n=0 -> fetch addresses 0x140, 0x160 into bank 1; line 0 video reads bank 0, pixel k = written data, 1-clk latency.
REQ-018 vscale2x=1, stride=64 -> target lines 0,1 fetch from 0x100; lines 2,3 fetch from 0x140.
REQ-019 Withhold gnt across the next hsync -> o_underflow=1, old line dropped, next bursts from new line address; clr pulse -> 0.
REQ-020 Window 10..20, line 5 -> no req, o_video_data=0; assert i_psram_rst_n low during DATA -> req=0, FSM IDLE next cycle.
